// File: rtl/axi_slv_line_des.sv
// AXI4 slave burst deserializer: 64-bit INCR/WRAP beats <-> one 256-bit line request.
// Define LINE_DES_WRAP_EN to accept WRAP bursts (len 1 or 3); otherwise WRAP returns SLVERR.

package axi_line_pkg;

    localparam int CFG_SYSBUS_ADDR_BITS = 48;
    localparam int CFG_SYSBUS_ID_BITS   = 5;
    localparam int CFG_SYSBUS_USER_BITS = 1;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic                            aw_valid;
        logic [CFG_SYSBUS_ADDR_BITS-1:0] aw_addr;
        logic [7:0]                      aw_len;
        logic [2:0]                      aw_size;
        logic [1:0]                      aw_burst;
        logic [CFG_SYSBUS_ID_BITS-1:0]   aw_id;
        logic [CFG_SYSBUS_USER_BITS-1:0] aw_user;
        logic                            w_valid;
        logic [63:0]                     w_data;
        logic                            w_last;
        logic [7:0]                      w_strb;
        logic [CFG_SYSBUS_USER_BITS-1:0] w_user;
        logic                            b_ready;
        logic                            ar_valid;
        logic [CFG_SYSBUS_ADDR_BITS-1:0] ar_addr;
        logic [7:0]                      ar_len;
        logic [2:0]                      ar_size;
        logic [1:0]                      ar_burst;
        logic [CFG_SYSBUS_ID_BITS-1:0]   ar_id;
        logic [CFG_SYSBUS_USER_BITS-1:0] ar_user;
        logic                            r_ready;
    } axi4_slave_in_type;

    typedef struct packed {
        logic                            aw_ready;
        logic                            w_ready;
        logic                            b_valid;
        logic [1:0]                      b_resp;
        logic [CFG_SYSBUS_ID_BITS-1:0]   b_id;
        logic [CFG_SYSBUS_USER_BITS-1:0] b_user;
        logic                            ar_ready;
        logic                            r_valid;
        logic [1:0]                      r_resp;
        logic [63:0]                     r_data;
        logic                            r_last;
        logic [CFG_SYSBUS_ID_BITS-1:0]   r_id;
        logic [CFG_SYSBUS_USER_BITS-1:0] r_user;
    } axi4_slave_out_type;

endpackage

module axi_slv_line_des
    import axi_line_pkg::*;
#(
    parameter int abits = 48
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  axi4_slave_in_type  i_xslvi,
    output axi4_slave_out_type o_xslvo,
    output logic               o_req_valid,
    output logic               o_req_write,
    output logic [abits-6:0]   o_req_addr,
    output logic [255:0]       o_req_wdata,
    output logic [31:0]        o_req_wstrb,
    input  logic               i_req_ready,
    input  logic               i_resp_valid,
    input  logic [255:0]       i_resp_rdata,
    input  logic               i_resp_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_MEM_REQ,
        ST_MEM_WAIT,
        ST_WRESP,
        ST_RDATA
    } state_e;

    state_e                          state_q, state_d;
    logic [CFG_SYSBUS_ID_BITS-1:0]   id_q, id_d;
    logic [CFG_SYSBUS_USER_BITS-1:0] user_q, user_d;
    logic [abits-6:0]                addr_q, addr_d;
    logic [7:0]                      cnt_q, cnt_d;
    logic [1:0]                      bidx_q, bidx_d;
    logic [1:0]                      mask_q, mask_d;
    logic                            write_q, write_d;
    logic                            err_q, err_d;
    logic [255:0]                    line_q, line_d;
    logic [31:0]                     wstrb_q, wstrb_d;

    logic       ar_ok, aw_ok;
    logic [1:0] bidx_next;

    function automatic logic burst_legal(input logic [1:0] bidx, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
        logic ok;
        ok = (size == 3'd3) && (len <= 8'd3);
        case (burst)
            AXI_BURST_INCR: ok = ok && (({1'b0, bidx} + {1'b0, len[1:0]}) <= 3'd3);
`ifdef LINE_DES_WRAP_EN
            AXI_BURST_WRAP: ok = ok && len[0];
`endif
            default:        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Step mask: 2'b11 gives a plain increment, len[1:0] confines WRAP to its aligned block.
    function automatic logic [1:0] step_mask(input logic ok, input logic [1:0] burst,
                                             input logic [7:0] len);
        return (ok && burst == AXI_BURST_WRAP) ? len[1:0] : 2'b11;
    endfunction

    assign ar_ok = burst_legal(i_xslvi.ar_addr[4:3], i_xslvi.ar_len,
                               i_xslvi.ar_size, i_xslvi.ar_burst);
    assign aw_ok = burst_legal(i_xslvi.aw_addr[4:3], i_xslvi.aw_len,
                               i_xslvi.aw_size, i_xslvi.aw_burst);
    assign bidx_next = (bidx_q & ~mask_q) | ((bidx_q + 2'd1) & mask_q);

    always_comb begin
        // NOTE: every _d starts from its _q, so no branch can leave a signal unassigned and infer a latch.
        state_d = state_q;
        id_d    = id_q;
        user_d  = user_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        bidx_d  = bidx_q;
        mask_d  = mask_q;
        write_d = write_q;
        err_d   = err_q;
        line_d  = line_q;
        wstrb_d = wstrb_q;

        case (state_q)
            ST_IDLE: begin
                if (i_xslvi.ar_valid) begin
                    id_d    = i_xslvi.ar_id;
                    user_d  = i_xslvi.ar_user;
                    addr_d  = i_xslvi.ar_addr[abits-1:5];
                    cnt_d   = i_xslvi.ar_len;
                    bidx_d  = i_xslvi.ar_addr[4:3];
                    mask_d  = step_mask(ar_ok, i_xslvi.ar_burst, i_xslvi.ar_len);
                    write_d = 1'b0;
                    err_d   = !ar_ok;
                    if (ar_ok) begin
                        state_d = ST_MEM_REQ;
                    end else begin
                        line_d  = '0;
                        state_d = ST_RDATA;
                    end
                end else if (i_xslvi.aw_valid) begin
                    id_d    = i_xslvi.aw_id;
                    user_d  = i_xslvi.aw_user;
                    addr_d  = i_xslvi.aw_addr[abits-1:5];
                    cnt_d   = i_xslvi.aw_len;
                    bidx_d  = i_xslvi.aw_addr[4:3];
                    mask_d  = step_mask(aw_ok, i_xslvi.aw_burst, i_xslvi.aw_len);
                    write_d = 1'b1;
                    err_d   = !aw_ok;
                    line_d  = '0;
                    wstrb_d = '0;
                    state_d = ST_WDATA;
                end
            end

            ST_WDATA: begin
                if (i_xslvi.w_valid) begin
                    line_d[{bidx_q, 6'd0} +: 64] = i_xslvi.w_data;
                    wstrb_d[{bidx_q, 3'd0} +: 8] = i_xslvi.w_strb;
                    bidx_d = bidx_next;
                    cnt_d  = cnt_q - 8'd1;
                    // w_last is not trusted; the beat counter alone ends the burst.
                    if (cnt_q == 8'd0) begin
                        state_d = err_q ? ST_WRESP : ST_MEM_REQ;
                    end
                end
            end

            ST_MEM_REQ: begin
                if (i_req_ready) begin
                    state_d = ST_MEM_WAIT;
                end
            end

            ST_MEM_WAIT: begin
                if (i_resp_valid) begin
                    err_d = err_q | i_resp_err;
                    if (write_q) begin
                        state_d = ST_WRESP;
                    end else begin
                        line_d  = i_resp_rdata;
                        state_d = ST_RDATA;
                    end
                end
            end

            ST_WRESP: begin
                if (i_xslvi.b_ready) begin
                    state_d = ST_IDLE;
                end
            end

            ST_RDATA: begin
                if (i_xslvi.r_ready) begin
                    bidx_d = bidx_next;
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            user_q  <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            bidx_q  <= '0;
            mask_q  <= 2'b11;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            // NOTE: line_q/wstrb_q are a flop bank, not a RAM macro, so they take the async reset too.
            line_q  <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            user_q  <= user_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            mask_q  <= mask_d;
            write_q <= write_d;
            err_q   <= err_d;
            line_q  <= line_d;
            wstrb_q <= wstrb_d;
        end
    end

    always_comb begin
        o_xslvo          = '0;
        o_xslvo.ar_ready = (state_q == ST_IDLE);
        o_xslvo.aw_ready = (state_q == ST_IDLE) && !i_xslvi.ar_valid;
        o_xslvo.w_ready  = (state_q == ST_WDATA);
        o_xslvo.b_valid  = (state_q == ST_WRESP);
        o_xslvo.b_resp   = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        o_xslvo.b_id     = id_q;
        o_xslvo.b_user   = user_q;
        o_xslvo.r_valid  = (state_q == ST_RDATA);
        o_xslvo.r_resp   = err_q ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        o_xslvo.r_data   = line_q[{bidx_q, 6'd0} +: 64];
        o_xslvo.r_last   = (cnt_q == 8'd0);
        o_xslvo.r_id     = id_q;
        o_xslvo.r_user   = user_q;
    end

    assign o_req_valid = (state_q == ST_MEM_REQ);
    assign o_req_write = write_q;
    assign o_req_addr  = addr_q;
    assign o_req_wdata = line_q;
    assign o_req_wstrb = wstrb_q;

    logic unused_ok;
    assign unused_ok = ^{i_xslvi.w_last, i_xslvi.w_user,
                         i_xslvi.aw_addr[2:0], i_xslvi.ar_addr[2:0]};

endmodule

// File: tb/tb_axi_slv_line_des.sv
// Directed bench for axi_slv_line_des: AXI master driver, one-cycle memory responder,
// hand-computed expectations for each transaction.

module tb_axi_slv_line_des;
    import axi_line_pkg::*;

    logic               clk;
    logic               rst_n;
    axi4_slave_in_type  xslvi;
    axi4_slave_out_type xslvo;
    logic               req_valid;
    logic               req_write;
    logic [42:0]        req_addr;
    logic [255:0]       req_wdata;
    logic [31:0]        req_wstrb;
    logic               req_ready;
    logic               resp_valid;
    logic [255:0]       resp_rdata;
    logic               resp_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // memory model state
    int           req_cnt = 0;
    logic [255:0] mem_line;
    logic         mem_err;
    logic [42:0]  log_addr;
    logic [255:0] log_wdata;
    logic [31:0]  log_wstrb;
    logic         log_write;

    // collected read beats
    logic [63:0] r_dat [8];
    logic [1:0]  r_rsp [8];
    logic        r_lst [8];
    int          r_first_cyc;

    axi_slv_line_des #(.abits(48)) dut (
        .i_clk        (clk),
        .i_nrst       (rst_n),
        .i_xslvi      (xslvi),
        .o_xslvo      (xslvo),
        .o_req_valid  (req_valid),
        .o_req_write  (req_write),
        .o_req_addr   (req_addr),
        .o_req_wdata  (req_wdata),
        .o_req_wstrb  (req_wstrb),
        .i_req_ready  (req_ready),
        .i_resp_valid (resp_valid),
        .i_resp_rdata (resp_rdata),
        .i_resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory: answers each accepted request one cycle later.
    initial begin
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                req_cnt++;
                log_addr  = req_addr;
                log_wdata = req_wdata;
                log_wstrb = req_wstrb;
                log_write = req_write;
                @(posedge clk); #1;
                resp_valid = 1'b1;
                resp_rdata = mem_line;
                resp_err   = mem_err;
                @(posedge clk); #1;
                resp_valid = 1'b0;
            end
        end
    end

    task automatic ar_send(input logic [47:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [4:0] id, output int hs);
        xslvi.ar_addr  = addr;
        xslvi.ar_len   = len;
        xslvi.ar_burst = burst;
        xslvi.ar_size  = size;
        xslvi.ar_id    = id;
        xslvi.ar_valid = 1'b1;
        hs = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (xslvo.ar_ready) hs = cyc;
            @(posedge clk); #1;
            if (hs >= 0) break;
        end
        xslvi.ar_valid = 1'b0;
        if (hs < 0) check("ar_timeout", 0, 1);
    endtask

    task automatic aw_send(input logic [47:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [2:0] size, input logic [4:0] id, output int hs);
        xslvi.aw_addr  = addr;
        xslvi.aw_len   = len;
        xslvi.aw_burst = burst;
        xslvi.aw_size  = size;
        xslvi.aw_id    = id;
        xslvi.aw_valid = 1'b1;
        hs = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (xslvo.aw_ready) hs = cyc;
            @(posedge clk); #1;
            if (hs >= 0) break;
        end
        xslvi.aw_valid = 1'b0;
        if (hs < 0) check("aw_timeout", 0, 1);
    endtask

    task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last,
                          output int hs);
        xslvi.w_data  = data;
        xslvi.w_strb  = strb;
        xslvi.w_last  = last;
        xslvi.w_valid = 1'b1;
        hs = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (xslvo.w_ready) hs = cyc;
            @(posedge clk); #1;
            if (hs >= 0) break;
        end
        xslvi.w_valid = 1'b0;
        if (hs < 0) check("w_timeout", 0, 1);
    endtask

    task automatic b_recv(output logic [1:0] resp, output logic [4:0] id, output int seen);
        xslvi.b_ready = 1'b1;
        seen = -1;
        resp = 2'bxx;
        id   = 'x;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (xslvo.b_valid) begin
                seen = cyc;
                resp = xslvo.b_resp;
                id   = xslvo.b_id;
            end
            @(posedge clk); #1;
            if (seen >= 0) break;
        end
        xslvi.b_ready = 1'b0;
        if (seen < 0) check("b_timeout", 0, 1);
    endtask

    task automatic r_recv(input int n, input bit toggle, output int last_cyc);
        int idx;
        idx = 0;
        last_cyc = -1;
        r_first_cyc = -1;
        for (int i = 0; i < 100; i++) begin
            xslvi.r_ready = toggle ? (i % 2 == 1) : 1'b1;
            @(negedge clk);
            if (xslvo.r_valid && xslvi.r_ready) begin
                if (idx == 0) r_first_cyc = cyc;
                r_dat[idx] = xslvo.r_data;
                r_rsp[idx] = xslvo.r_resp;
                r_lst[idx] = xslvo.r_last;
                last_cyc = cyc;
                idx++;
            end
            @(posedge clk); #1;
            if (idx == n) break;
        end
        xslvi.r_ready = 1'b0;
        if (idx < n) check("r_timeout", idx, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d [4];
        logic [1:0]  resp;
        logic [4:0]  id;
        int hs, hs2, seen, last, base;

        d[0] = 64'h0011223344556677;
        d[1] = 64'h8899AABBCCDDEEFF;
        d[2] = 64'h0F1E2D3C4B5A6978;
        d[3] = 64'hF0E1D2C3B4A59687;

        xslvi     = '0;
        req_ready = 1'b1;
        mem_line  = '0;
        mem_err   = 1'b0;
        rst_n     = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ar_ready", xslvo.ar_ready, 1);
        check("rst_aw_ready", xslvo.aw_ready, 1);
        check("rst_w_ready",  xslvo.w_ready, 0);
        check("rst_b_valid",  xslvo.b_valid, 0);
        check("rst_r_valid",  xslvo.r_valid, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_wstrb",    req_wstrb, 0);
        check("rst_line",     req_wdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // full-line write
        base = req_cnt;
        aw_send(48'h1000, 8'd3, AXI_BURST_INCR, 3'd3, 5'd3, hs);
        for (int k = 0; k < 4; k++) w_send(d[k], 8'hFF, k == 3, hs);
        b_recv(resp, id, seen);
        check("wr_req_cnt", req_cnt, base + 1);
        check("wr_req_addr", log_addr, 43'h80);
        check("wr_req_write", log_write, 1);
        check("wr_req_wdata", log_wdata, {d[3], d[2], d[1], d[0]});
        check("wr_req_wstrb", log_wstrb, 32'hFFFFFFFF);
        check("wr_b_resp", resp, AXI_RESP_OKAY);
        check("wr_b_id", id, 5'd3);
        check("wr_b_latency", seen, hs + 3);

        // partial read
        base = req_cnt;
        mem_line = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        ar_send(48'h2010, 8'd1, AXI_BURST_INCR, 3'd3, 5'd7, hs);
        r_recv(2, 1'b0, last);
        check("rd_req_cnt", req_cnt, base + 1);
        check("rd_req_addr", log_addr, 43'h100);
        check("rd_req_write", log_write, 0);
        check("rd_beat0", r_dat[0], 64'hA2);
        check("rd_beat1", r_dat[1], 64'hA3);
        check("rd_last0", r_lst[0], 0);
        check("rd_last1", r_lst[1], 1);
        check("rd_resp", r_rsp[1], AXI_RESP_OKAY);
        check("rd_latency", r_first_cyc, hs + 3);

        // illegal INCR read crosses the line end
        base = req_cnt;
        ar_send(48'h18, 8'd2, AXI_BURST_INCR, 3'd3, 5'd1, hs);
        r_recv(3, 1'b0, last);
        check("ill_no_req", req_cnt, base);
        for (int k = 0; k < 3; k++) begin
            check("ill_data", r_dat[k], 0);
            check("ill_resp", r_rsp[k], AXI_RESP_SLVERR);
            check("ill_last", r_lst[k], k == 2);
        end

        // write held off by the memory: request stays stable, no early B
        req_ready = 1'b0;
        aw_send(48'h48, 8'd0, AXI_BURST_INCR, 3'd3, 5'd2, hs);
        w_send(d[2], 8'h0F, 1'b1, hs);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_req_valid", req_valid, 1);
            check("bp_req_addr", req_addr, 43'h2);
            check("bp_req_wstrb", req_wstrb, 32'h00000F00);
            check("bp_req_wdata", req_wdata[127:64], d[2]);
            check("bp_no_b", xslvo.b_valid, 0);
            @(posedge clk); #1;
        end
        req_ready = 1'b1;
        b_recv(resp, id, seen);
        check("bp_b_resp", resp, AXI_RESP_OKAY);
        check("bp_b_id", id, 5'd2);

        // read with r_ready toggling
        mem_line = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
        ar_send(48'h3000, 8'd3, AXI_BURST_INCR, 3'd3, 5'd4, hs);
        r_recv(4, 1'b1, last);
        for (int k = 0; k < 4; k++) begin
            check("tog_data", r_dat[k], 64'hC0 + 64'(k));
            check("tog_last", r_lst[k], k == 3);
        end
        @(negedge clk);
        check("tog_no_extra", xslvo.r_valid, 0);
        @(posedge clk); #1;

        // memory error on a read
        mem_err = 1'b1;
        ar_send(48'h0, 8'd0, AXI_BURST_INCR, 3'd3, 5'd5, hs);
        r_recv(1, 1'b0, last);
        check("merr_resp", r_rsp[0], AXI_RESP_SLVERR);
        mem_err = 1'b0;

        // illegal write (size 2): B SLVERR, memory untouched
        base = req_cnt;
        aw_send(48'h0, 8'd0, AXI_BURST_INCR, 3'd2, 5'd6, hs);
        w_send(d[0], 8'hFF, 1'b1, hs);
        b_recv(resp, id, seen);
        check("illw_resp", resp, AXI_RESP_SLVERR);
        check("illw_no_req", req_cnt, base);

        // AR and AW together: AR wins, AW waits for the read's last beat
        mem_line = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
        xslvi.aw_addr  = 48'h1008;
        xslvi.aw_len   = 8'd1;
        xslvi.aw_burst = AXI_BURST_INCR;
        xslvi.aw_size  = 3'd3;
        xslvi.aw_id    = 5'd9;
        xslvi.aw_valid = 1'b1;
        xslvi.ar_addr  = 48'h1000;
        xslvi.ar_len   = 8'd0;
        xslvi.ar_burst = AXI_BURST_INCR;
        xslvi.ar_size  = 3'd3;
        xslvi.ar_id    = 5'd8;
        xslvi.ar_valid = 1'b1;
        @(negedge clk);
        check("prio_ar_ready", xslvo.ar_ready, 1);
        check("prio_aw_ready", xslvo.aw_ready, 0);
        @(posedge clk); #1;
        xslvi.ar_valid = 1'b0;
        r_recv(1, 1'b0, last);
        check("prio_rd_data", r_dat[0], 64'hE0);
        aw_send(48'h1008, 8'd1, AXI_BURST_INCR, 3'd3, 5'd9, hs2);
        check("prio_aw_after_r", hs2, last + 1);
        w_send(d[1], 8'hFF, 1'b0, hs);
        w_send(d[3], 8'hFF, 1'b1, hs);
        b_recv(resp, id, seen);
        check("prio_wstrb", log_wstrb, 32'h00FFFF00);
        check("prio_wdata", log_wdata[191:64], {d[3], d[1]});
        check("prio_b_id", id, 5'd9);

        // WRAP read from word 2
        base = req_cnt;
        mem_line = {64'hB3, 64'hB2, 64'hB1, 64'hB0};
        ar_send(48'h30, 8'd3, AXI_BURST_WRAP, 3'd3, 5'd10, hs);
        r_recv(4, 1'b0, last);
`ifdef LINE_DES_WRAP_EN
        check("wrap_req", req_cnt, base + 1);
        check("wrap_b0", r_dat[0], 64'hB2);
        check("wrap_b1", r_dat[1], 64'hB3);
        check("wrap_b2", r_dat[2], 64'hB0);
        check("wrap_b3", r_dat[3], 64'hB1);
        check("wrap_resp", r_rsp[3], AXI_RESP_OKAY);
`else
        check("wrap_no_req", req_cnt, base);
        for (int k = 0; k < 4; k++) begin
            check("wrap_data", r_dat[k], 0);
            check("wrap_resp", r_rsp[k], AXI_RESP_SLVERR);
        end
`endif
        check("wrap_last", r_lst[3], 1);

        // reset in the middle of a write burst
        aw_send(48'h0, 8'd3, AXI_BURST_INCR, 3'd3, 5'd11, hs);
        w_send(d[0], 8'hFF, 1'b0, hs);
        rst_n = 1'b0;
        #1;
        check("mid_rst_w_ready", xslvo.w_ready, 0);
        check("mid_rst_ar_ready", xslvo.ar_ready, 1);
        check("mid_rst_b_valid", xslvo.b_valid, 0);
        check("mid_rst_req", req_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_no_b", xslvo.b_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_slv_line_des.md
# axi_slv_line_des

AXI4 slave-side burst deserializer: the responder counterpart of the L2 bus serializer. It accepts 64-bit INCR/WRAP bursts of at most one 256-bit line from the system AXI4 fabric. Write beats are assembled into one line-wide memory write; a line read is split into response beats. It sits between the AXI interconnect and line-wide slave memories (L2-backed SRAM, boot ROM model).

## Interface
- abits, 48, address width; line address is abits-5 bits.
- i_clk  in  1  CPU clock, all logic on rising edge.
- i_nrst  in  1  reset, asynchronous, active LOW.
- i_xslvi  in  axi4_slave_in_type  AW/W/B-ready/AR/R-ready from the master. busw=64; only ID width from the package is used.
- o_xslvo  out  axi4_slave_out_type  ready signals, B and R channels.
- o_req_valid  out  1  line request valid.
- o_req_write  out  1  1=write, 0=read.
- o_req_addr  out  abits-5  line address = AXI addr[abits-1:5].
- o_req_wdata  out  256  assembled line.
- o_req_wstrb  out  32  byte enables; bytes not written are 0.
- i_req_ready  in  1  memory accepts request.
- i_resp_valid  in  1  memory response (one per accepted request, ≥1 cycle after).
- i_resp_rdata  in  256  read line.
- i_resp_err  in  1  memory error → resp 2'b10.

## Operation
- States: Idle, WData, MemReq, MemWait, WResp, RData.
- Idle: ar_ready=1; aw_ready=!ar_valid, so AR has priority when both are valid. On handshake, latch id, user, addr, len and burst. Beat index bidx = addr[4:3]; beat counter = len.
- Legality, checked in the handshake cycle:
  - size must be 3'd3 and len ≤ 3.
  - INCR bursts need bidx+len ≤ 3.
  - Illegal requests set err. They skip the memory, still complete the full len+1 beat protocol, and return resp 2'b10.
- Write path:
  - WData: w_ready=1. Each beat stores w_data/w_strb at bidx, bidx advances, counter decrements.
  - The beat with counter==0 goes to MemReq, or straight to WResp if err.
  - A w_last mismatch with the counter is ignored; the counter governs.
  - wstrb is cleared at AW accept.
- Read path: the AR handshake goes to MemReq, or to RData with zero data if err.
- MemReq: o_req_valid=1 until i_req_ready, then MemWait. Address and data are held stable while valid and not ready.
- MemWait: on i_resp_valid, capture rdata and err|=i_resp_err. A write then goes to WResp, a read to RData.
- WResp: b_valid=1, b_resp = err?2'b10:2'b00, b_id = latched id. On b_ready go to Idle.
- RData:
  - r_valid=1, r_data = line[bidx*64 +: 64], r_resp from err, r_last when counter==0.
  - On r_ready, advance bidx and decrement the counter.
  - Accepting the last beat returns to Idle.
- bidx arithmetic is 2-bit. INCR never wraps because the legality check prevents it; WRAP wraps modulo 4 (see Configuration).
- Memory responses arriving outside MemWait are ignored.

## Timing
- Reset values:
  - state=Idle; all o_xslvo valids 0; ar_ready=1; aw_ready=1; w_ready=0.
  - o_req_valid=0; line and wstrb registers 0.
- All outputs are decoded from registered state. aw_ready depends combinationally on i_xslvi.ar_valid.
- Write latency: last W beat accepted at cycle N → o_req_valid at N+1 → with i_req_ready=1 and a 1-cycle memory response, b_valid at N+3.
- Read latency: AR accepted at N → o_req_valid at N+1 → first r_valid at N+3; one beat per cycle while r_ready=1.
- Throughput: one transaction in flight; a new AR/AW is accepted no earlier than the cycle after B or the last R handshake.
- Asynchronous reset mid-burst aborts immediately to Idle. No B or R is issued for the aborted transaction.

## Configuration
- LINE_DES_WRAP_EN defined:
  - WRAP bursts (burst=2'b10) with len ∈ {1,3} and size 3 are legal.
  - bidx wraps modulo (len+1) inside the aligned block: bidx_next = (bidx & ~len) | ((bidx+1) & len).
- Undefined: any WRAP burst is illegal → SLVERR, no memory access.

## Test plan
- Full-line write: AW addr 0x1000, len 3, size 3, INCR; beats D0..D3, strb 0xFF → one request: addr 0x80, wdata={D3,D2,D1,D0}, wstrb 0xFFFFFFFF; then B resp 0.
- Partial read: AR addr 0x2010, len 1 → request addr 0x100; the bench returns a line with word k = k+0xA0 → R beats 0xA2, 0xA3, r_last on the second beat.
- Illegal INCR: AR addr 0x18, len 2 → no o_req_valid; 3 R beats of 0 with resp 2'b10, last flagged.
- Backpressure: write with i_req_ready low for 5 cycles → request fields stable; B only after the response; r_ready toggling on reads → no beat lost or duplicated.
- Simultaneous AR and AW in Idle → AR accepted first; AW accepted after the read's last beat.
- With LINE_DES_WRAP_EN: WRAP AR addr 0x30, len 3 → beat order word 2,3,0,1. Without the macro → 4 beats with SLVERR.
